// File: rtl/comet_uart_tx_io_if.sv
// rtl/comet_uart_tx_io_if.sv - COMET II data-memory bus port bundle for the UART TX responder
interface comet_uart_tx_io_if;
   logic        re;
   logic [15:0] raddr;
   logic [15:0] rdata;
   logic        rsel;
   logic        we;
   logic [15:0] waddr;
   logic [15:0] wdata;

   modport master (output re, output raddr, input rdata, input rsel,
                   output we, output waddr, output wdata);
   modport slave  (input re, input raddr, output rdata, output rsel,
                   input we, input waddr, input wdata);
endinterface

// File: rtl/comet_uart_tx_io.sv
// rtl/comet_uart_tx_io.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
module comet_uart_tx_io #(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter int          CLKS_PER_BIT = 69,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic                mclk,
   input  logic                rst,
   comet_uart_tx_io_if.slave   bus,
   output logic                txd,
   output logic                tx_busy
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [15:0]   baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          rsel_q, rsel_d;

   logic          fifo_empty, fifo_full, baud_end, pop, push_ok;
   logic          wr_data_hit, wr_stat_hit, rd_data_hit, rd_stat_hit;
   logic [15:0]   status;
   logic [7:0]    unused_wdata_hi;

   assign unused_wdata_hi = bus.wdata[15:8];

   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == DEPTH_C);
   assign baud_end    = (baud_q == BAUD_LAST);
   assign wr_data_hit = bus.we && (bus.waddr == BASE_ADDR);
   assign wr_stat_hit = bus.we && (bus.waddr == STAT_ADDR);
   assign rd_data_hit = (bus.raddr == BASE_ADDR);
   assign rd_stat_hit = (bus.raddr == STAT_ADDR);
   // A full FIFO still accepts a byte when the shifter pops on the same edge.
   assign push_ok     = wr_data_hit && (!fifo_full || pop);
   assign status      = {8'h00, 4'(count_q), ovf_q, fifo_empty, fifo_full, state_q != IDLE};

   assign txd         = txd_q;
   assign tx_busy     = (state_q != IDLE) || !fifo_empty;
   assign bus.rdata   = rdata_q;
   assign bus.rsel    = rsel_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               baud_d  = '0;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Line level follows the next state so txd changes on the same edge as the state.
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop);
      ovf_d    = ovf_q;
      if (wr_stat_hit && bus.wdata[3]) ovf_d = 1'b0;
      if (wr_data_hit && !push_ok)     ovf_d = 1'b1;
      rdata_d = rdata_q;
      rsel_d  = rsel_q;
      if (bus.re) begin
         rsel_d  = rd_data_hit || rd_stat_hit;
         rdata_d = rd_stat_hit ? status : 16'h0000;
      end
   end

   always_ff @(posedge mclk) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.wdata[7:0];
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
         rsel_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         rsel_q   <= rsel_d;
      end
   end
endmodule

// File: tb/tb_comet_uart_tx_io.sv
// tb/tb_comet_uart_tx_io.sv - directed bench for comet_uart_tx_io
module tb_comet_uart_tx_io;
   localparam int CPB = 4;

   logic mclk = 1'b0;
   logic rst;
   logic txd, tx_busy;
   comet_uart_tx_io_if bus();

   comet_uart_tx_io #(.BASE_ADDR(16'hFF00), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .mclk(mclk), .rst(rst), .bus(bus), .txd(txd), .tx_busy(tx_busy));

   always #5 mclk = ~mclk;

   int checks = 0;
   int passed = 0;

   // Independent line receiver: detects start edge, samples mid-bit.
   logic [7:0] rxq[$];
   logic [7:0] rx_byte;
   logic       rx_act = 1'b0;
   int         rx_cnt, rx_b;
   int         rx_frame_err = 0;

   always @(negedge mclk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (txd === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            rx_b = rx_cnt / CPB;
            if (rx_b >= 1 && rx_b <= 8) rx_byte[rx_b-1] = txd;
            else if (rx_b == 9) begin
               if (txd !== 1'b1) rx_frame_err++;
               rxq.push_back(rx_byte);
               rx_act = 1'b0;
            end
         end
      end
   end

   task automatic tick;
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
      tick;
      bus.we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic s);
      bus.re = 1'b1; bus.raddr = a;
      tick;
      bus.re = 1'b0;
      d = bus.rdata;
      s = bus.rsel;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (tx_busy && n < limit) begin
         tick;
         n++;
      end
      chk("idle_timeout", tx_busy, 1'b0);
   endtask

   function automatic logic stream_bit(input int j);
      logic [7:0] by [3];
      int p;
      by[0] = 8'h01; by[1] = 8'h80; by[2] = 8'hFF;
      p = (j % 40) / 4;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return by[j/40][p-1];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] d;
      logic        s;
      logic [9:0]  pat;
      logic [15:0] s19, s59, s99;
      int          err;

      rst = 1'b1;
      bus.re = 1'b0; bus.raddr = '0;
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
      tick; tick;
      chk("rst_txd", txd, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_rdata", bus.rdata, 16'h0000);
      chk("rst_rsel", bus.rsel, 1'b0);
      rst = 1'b0;
      rd(16'hFF01, d, s);
      chk("rst_status", d, 16'h0004);
      chk("rst_status_rsel", s, 1'b1);

      // Single byte 0x55
      rxq.delete();
      wr(16'hFF00, 16'h1255);
      chk("t2_txd_k", txd, 1'b1);
      chk("t2_busy_k", tx_busy, 1'b1);
      tick;
      chk("t2_fall", txd, 1'b0);
      pat = 10'b10_1010_1010;
      for (int i = 0; i < 10; i++) begin
         repeat ((i == 0) ? 1 : CPB) tick;
         chk($sformatf("t2_bit%0d", i), txd, pat[i]);
      end
      repeat (2) tick;
      chk("t2_busy_40", tx_busy, 1'b1);
      tick;
      chk("t2_busy_41", tx_busy, 1'b0);
      chk("t2_rx_n", rxq.size(), 1);
      chk("t2_rx_byte", (rxq.size() > 0) ? rxq[0] : 8'hXX, 8'h55);

      // Back-to-back 0x01, 0x80, 0xFF
      rxq.delete();
      wr(16'hFF00, 16'h0001);
      wr(16'hFF00, 16'h0080);
      err = (txd !== stream_bit(0)) ? 1 : 0;
      bus.we = 1'b1; bus.waddr = 16'hFF00; bus.wdata = 16'h00FF;
      bus.re = 1'b1; bus.raddr = 16'hFF01;
      s19 = '0; s59 = '0; s99 = '0;
      for (int j = 1; j < 120; j++) begin
         tick;
         bus.we = 1'b0;
         if (txd !== stream_bit(j)) err++;
         if (j == 19) s19 = bus.rdata;
         if (j == 59) s59 = bus.rdata;
         if (j == 99) s99 = bus.rdata;
      end
      bus.re = 1'b0;
      chk("t3_stream_errs", err, 0);
      chk("t3_status_cnt2", s19, 16'h0021);
      chk("t3_status_cnt1", s59, 16'h0011);
      chk("t3_status_cnt0", s99, 16'h0005);
      tick;
      chk("t3_end_txd", txd, 1'b1);
      chk("t3_end_busy", tx_busy, 1'b0);
      chk("t3_rx_n", rxq.size(), 3);
      chk("t3_rx_bytes", (rxq.size() == 3) ? {8'h00, rxq[0], rxq[1], rxq[2]} : 32'hDEAD, 32'h0001_80FF);

      // Overflow: ten bytes into an 8-deep FIFO
      rxq.delete();
      rx_frame_err = 0;
      for (int i = 0; i < 10; i++) wr(16'hFF00, 16'(i));
      rd(16'hFF01, d, s);
      chk("t4_status_fields", {d[15:1], 1'b0}, 16'h008A);
      chk("t4_status_active", d[0], 1'b1);
      wr(16'hFF01, 16'h0008);
      rd(16'hFF01, d, s);
      chk("t4_status_cleared", d, 16'h0083);
      wait_idle(500);
      chk("t4_rx_n", rxq.size(), 9);
      err = 0;
      for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== 8'(i)) err++;
      chk("t4_rx_order", err, 0);
      chk("t4_frame_err", rx_frame_err, 0);

      // Address decode
      rd(16'hFF02, d, s);
      chk("t5_ff02_rdata", d, 16'h0000);
      chk("t5_ff02_rsel", s, 1'b0);
      rd(16'h0010, d, s);
      chk("t5_0010_rdata", d, 16'h0000);
      chk("t5_0010_rsel", s, 1'b0);
      wr(16'hFF02, 16'h0041);
      rd(16'hFF01, d, s);
      chk("t5_count_after_ff02", d, 16'h0004);
      rd(16'hFF00, d, s);
      chk("t5_txdata_rdata", d, 16'h0000);
      chk("t5_txdata_rsel", s, 1'b1);
      chk("t5_busy", tx_busy, 1'b0);

      // Reset during DATA bit 3 with two bytes queued
      rxq.delete();
      wr(16'hFF00, 16'h00A5);
      wr(16'hFF00, 16'h003C);
      wr(16'hFF00, 16'h000F);
      repeat (16) tick;
      chk("t6_bit3_before_rst", txd, 1'b0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t6_txd_after_rst", txd, 1'b1);
      chk("t6_busy_after_rst", tx_busy, 1'b0);
      rd(16'hFF01, d, s);
      chk("t6_status", d, 16'h0004);
      err = 0;
      for (int i = 0; i < 100; i++) begin
         tick;
         if (txd !== 1'b1) err++;
      end
      chk("t6_line_quiet", err, 0);
      chk("t6_rx_n", rxq.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
